// File: rtl/data_mem_port.sv
// data_mem_port: load/store initiator for a single-port synchronous data RAM.
// Optional byte-lane access (read-modify-write byte stores) is built when DMP_BYTE_ACCESS_EN is defined.
module data_mem_port #(
  parameter int DATA_W = 32,
  parameter int RAM_AW = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [RAM_AW+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
`ifdef DMP_BYTE_ACCESS_EN
    WRITE = 3'd3,
`endif
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] RD_LAT_M1 = 2'(RD_LAT - 1);

  state_t              state_r, state_s;
  logic [1:0]          cnt_r, cnt_s;
  logic                write_r, write_s;
  logic                req_ready_r, req_ready_s;
  logic                resp_valid_r, resp_valid_s;
  logic [DATA_W-1:0]   resp_rdata_r, resp_rdata_s;
  logic                ram_we_r, ram_we_s;
  logic [RAM_AW-1:0]   ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0]   ram_din_r, ram_din_s;
  logic                word_store_s;
  logic                req_word_store_s;

`ifdef DMP_BYTE_ACCESS_EN
  logic                byte_r, byte_s;
  logic [1:0]          lane_r, lane_s;

  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                   input logic [7:0]        b,
                                                   input logic [1:0]        lane);
    logic [DATA_W-1:0] w;
    w = word;
    w[int'(lane)*8 +: 8] = b;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] pick_byte(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        lane);
    return {{(DATA_W-8){1'b0}}, word[int'(lane)*8 +: 8]};
  endfunction

  assign word_store_s     = write_r & ~byte_r;
  assign req_word_store_s = req_write & ~req_byte;
`else
  logic unused_s;
  assign unused_s         = ^{req_byte, req_addr[1:0]};
  assign word_store_s     = write_r;
  assign req_word_store_s = req_write;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    write_s      = write_r;
    ram_we_s     = 1'b0;
    resp_valid_s = 1'b0;
    ram_addr_s   = ram_addr_r;
    ram_din_s    = ram_din_r;
    resp_rdata_s = resp_rdata_r;
`ifdef DMP_BYTE_ACCESS_EN
    byte_s       = byte_r;
    lane_s       = lane_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          state_s    = ISSUE;
          cnt_s      = 2'd0;
          write_s    = req_write;
          ram_addr_s = req_addr[RAM_AW+1:2];
          ram_din_s  = req_wdata;
          ram_we_s   = req_word_store_s;
`ifdef DMP_BYTE_ACCESS_EN
          byte_s     = req_byte;
          lane_s     = req_addr[1:0];
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (word_store_s) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = {DATA_W{1'b0}};
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        // ram_dout is valid on the last count of the read latency
        if (cnt_r == RD_LAT_M1) begin
`ifdef DMP_BYTE_ACCESS_EN
          if (write_r) begin
            state_s   = WRITE;
            ram_we_s  = 1'b1;
            ram_din_s = merge_byte(ram_dout, ram_din_r[7:0], lane_r);
          end else begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = byte_r ? pick_byte(ram_dout, lane_r) : ram_dout;
          end
`else
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = ram_dout;
`endif
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
`ifdef DMP_BYTE_ACCESS_EN
      WRITE: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
        resp_rdata_s = {DATA_W{1'b0}};
      end
`endif
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      write_r      <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      ram_we_r     <= 1'b0;
      ram_addr_r   <= {RAM_AW{1'b0}};
      ram_din_r    <= {DATA_W{1'b0}};
`ifdef DMP_BYTE_ACCESS_EN
      byte_r       <= 1'b0;
      lane_r       <= 2'd0;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      write_r      <= write_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      ram_we_r     <= ram_we_s;
      ram_addr_r   <= ram_addr_s;
      ram_din_r    <= ram_din_s;
`ifdef DMP_BYTE_ACCESS_EN
      byte_r       <= byte_s;
      lane_r       <= lane_s;
`endif
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign ram_we     = ram_we_r;
  assign ram_addr   = ram_addr_r;
  assign ram_din    = ram_din_r;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: RD_LAT=1 instance plus an RD_LAT=2 instance for the top-word test.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_init = 1'b1;
  logic        req_v = 1'b0;
  logic        use2 = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;

  logic        req_valid1, req_ready1, resp_valid1, ram_we1;
  logic [31:0] resp_rdata1, ram_din1, dout1;
  logic [5:0]  ram_addr1;
  logic        req_valid2, req_ready2, resp_valid2, ram_we2;
  logic [31:0] resp_rdata2, ram_din2, dout2, p2;
  logic [5:0]  ram_addr2;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem2 [0:63];
  logic [31:0] exp1 [0:63];

  int n_checks = 0;
  int n_fail = 0;

  int          obs_lat, obs_we_cnt, obs_we_lat;
  logic [5:0]  obs_addr1;
  logic [31:0] obs_rdata;
  logic        obs_pulse2, obs_busy_ready;

  int          mon_we = 0;
  int          mon_resp = 0;
  int          mon_bad = 0;
  logic [5:0]  mon_addrs [$];

  logic        m_ready, m_resp, m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_rdata;

  assign req_valid1 = req_v & ~use2;
  assign req_valid2 = req_v & use2;
  assign m_ready = use2 ? req_ready2  : req_ready1;
  assign m_resp  = use2 ? resp_valid2 : resp_valid1;
  assign m_we    = use2 ? ram_we2     : ram_we1;
  assign m_addr  = use2 ? ram_addr2   : ram_addr1;
  assign m_rdata = use2 ? resp_rdata2 : resp_rdata1;

  always #5 clk = ~clk;

  data_mem_port #(.DATA_W(32), .RAM_AW(6), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(dout1));

  data_mem_port #(.DATA_W(32), .RAM_AW(6), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .ram_we(ram_we2),
    .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_dout(dout2));

  // Behavioural RAMs: latency 1 for dut, latency 2 for dut2
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 32'hC000_0000 | 32'(i);
        mem2[i] <= 32'hC000_0000 | 32'(i);
      end
    end else begin
      if (ram_we1) mem1[ram_addr1] <= ram_din1;
      if (ram_we2) mem2[ram_addr2] <= ram_din2;
    end
    dout1 <= mem1[ram_addr1];
    p2    <= mem2[ram_addr2];
    dout2 <= p2;
  end

  // Pulse monitor on the currently selected instance
  always @(negedge clk) begin
    if (m_we) begin
      mon_we <= mon_we + 1;
      mon_addrs.push_back(m_addr);
    end
    if (m_resp) mon_resp <= mon_resp + 1;
    if (m_ready && (m_we || m_resp)) mon_bad <= mon_bad + 1;
  end

  task automatic xact(input logic sel, input logic wr, input logic by,
                      input logic [7:0] a, input logic [31:0] d);
    int n;
    use2 = sel;
    @(negedge clk);
    req_write = wr; req_byte = by; req_addr = a; req_wdata = d; req_v = 1'b1;
    n = 0;
    while (m_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (m_ready !== 1'b1) begin n_fail++; $display("FAIL accept_wait: req_ready=%b required 1", m_ready); end
    @(posedge clk);
    #1 req_v = 1'b0;
    obs_lat = 0; obs_we_cnt = 0; obs_we_lat = 0; obs_addr1 = 6'h0; obs_busy_ready = 1'b0;
    do begin
      @(negedge clk);
      obs_lat++;
      if (obs_lat == 1) obs_addr1 = m_addr;
      if (m_we) begin obs_we_cnt++; obs_we_lat = obs_lat; end
      if (m_ready) obs_busy_ready = 1'b1;
    end while (m_resp !== 1'b1 && obs_lat < 20);
    obs_rdata = m_rdata;
    @(negedge clk);
    obs_pulse2 = m_resp;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready1, resp_valid1, resp_rdata1, ram_we1, ram_addr1, ram_din1} !== 72'h0)
      begin n_fail++; $display("FAIL reset_outputs1: got %h required 0", {req_ready1, resp_valid1, resp_rdata1, ram_we1, ram_addr1, ram_din1}); end
    n_checks++;
    if ({req_ready2, resp_valid2, ram_we2} !== 3'b000)
      begin n_fail++; $display("FAIL reset_outputs2: got %b required 000", {req_ready2, resp_valid2, ram_we2}); end
    ram_init = 1'b0;
    for (int i = 0; i < 64; i++) exp1[i] = 32'hC000_0000 | 32'(i);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b required 0", req_ready1); end
    @(negedge clk);
    n_checks++;
    if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b required 1", req_ready1); end
  endtask

  task automatic test_store_load();
    xact(1'b0, 1'b1, 1'b0, 8'h04, 32'hA0A0_A0A0);
    exp1[1] = 32'hA0A0_A0A0;
    n_checks++; if (obs_we_cnt !== 1) begin n_fail++; $display("FAIL t1_we_count: got %0d required 1", obs_we_cnt); end
    n_checks++; if (obs_we_lat !== 1) begin n_fail++; $display("FAIL t1_we_cycle: got %0d required 1", obs_we_lat); end
    n_checks++; if (obs_addr1 !== 6'd1) begin n_fail++; $display("FAIL t1_ram_addr: got %0d required 1", obs_addr1); end
    n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL t1_store_lat: got %0d required 2", obs_lat); end
    n_checks++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL t1_store_rdata: got %h required 0", obs_rdata); end
    n_checks++; if (obs_pulse2 !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_len: got %b required 0", obs_pulse2); end
    n_checks++; if (obs_busy_ready !== 1'b0) begin n_fail++; $display("FAIL t1_busy_ready: got %b required 0", obs_busy_ready); end
    n_checks++; if (mem1[1] !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL t1_ram_word: got %h required a0a0a0a0", mem1[1]); end
    xact(1'b0, 1'b0, 1'b0, 8'h04, 32'h0);
    n_checks++; if (obs_lat !== 3) begin n_fail++; $display("FAIL t1_load_lat: got %0d required 3", obs_lat); end
    n_checks++; if (obs_rdata !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL t1_load_data: got %h required a0a0a0a0", obs_rdata); end
    n_checks++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL t1_load_we: got %0d required 0", obs_we_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [7];
    logic [31:0] datas [7];
    int i, cyc, we0, resp0, q0, bad0;
    addrs = '{8'h04, 8'h0C, 8'h14, 8'h20, 8'h24, 8'h28, 8'h30};
    datas = '{32'hA0A0_A0A0, 32'h1111_1111, 32'h2222_2222, 32'h0B0B_0B0B,
              32'h1234_5678, 32'hDEAD_BEEF, 32'h6543_2121};
    use2 = 1'b0;
    @(negedge clk);
    we0 = mon_we; resp0 = mon_resp; q0 = mon_addrs.size(); bad0 = mon_bad;
    i = 0; cyc = 0;
    req_write = 1'b1; req_byte = 1'b0; req_addr = addrs[0]; req_wdata = datas[0]; req_v = 1'b1;
    while (i < 7 && cyc < 100) begin
      if (req_ready1 === 1'b1) begin
        @(posedge clk);
        #1;
        exp1[addrs[i] >> 2] = datas[i];
        i++;
        if (i < 7) begin req_addr = addrs[i]; req_wdata = datas[i]; end
        else req_v = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_v = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (i !== 7) begin n_fail++; $display("FAIL t2_accepts: got %0d required 7", i); end
    n_checks++; if (cyc !== 19) begin n_fail++; $display("FAIL t2_cycles: got %0d required 19", cyc); end
    n_checks++; if (mon_we - we0 !== 7) begin n_fail++; $display("FAIL t2_we_pulses: got %0d required 7", mon_we - we0); end
    n_checks++; if (mon_resp - resp0 !== 7) begin n_fail++; $display("FAIL t2_resp_pulses: got %0d required 7", mon_resp - resp0); end
    n_checks++; if (mon_bad !== bad0) begin n_fail++; $display("FAIL t2_ready_busy: got %0d required %0d", mon_bad, bad0); end
    for (int j = 0; j < 7; j++) begin
      n_checks++;
      if (mon_addrs.size() <= q0 + j || mon_addrs[q0 + j] !== addrs[j][7:2])
        begin n_fail++; $display("FAIL t2_we_addr%0d: got %0d required %0d", j, (mon_addrs.size() > q0 + j) ? mon_addrs[q0 + j] : 6'h3F, addrs[j][7:2]); end
    end
    for (int k = 0; k <= 12; k++) begin
      xact(1'b0, 1'b0, 1'b0, 8'(k * 4), 32'h0);
      n_checks++;
      if (obs_rdata !== exp1[k]) begin n_fail++; $display("FAIL t2_load%0d: got %h required %h", k, obs_rdata, exp1[k]); end
    end
  endtask

  task automatic test_unaligned_word();
    xact(1'b0, 1'b1, 1'b0, 8'h04, 32'h0B0B_0B0B);
    exp1[1] = 32'h0B0B_0B0B;
    xact(1'b0, 1'b0, 1'b0, 8'h07, 32'h0);
    n_checks++; if (obs_addr1 !== 6'd1) begin n_fail++; $display("FAIL t3_ram_addr: got %0d required 1", obs_addr1); end
    n_checks++; if (obs_rdata !== 32'h0B0B_0B0B) begin n_fail++; $display("FAIL t3_load_data: got %h required 0b0b0b0b", obs_rdata); end
  endtask

`ifdef DMP_BYTE_ACCESS_EN
  task automatic test_byte_access();
    xact(1'b0, 1'b1, 1'b0, 8'h30, 32'h6543_2121);
    xact(1'b0, 1'b1, 1'b1, 8'h31, 32'hABCD_EFFF);
    exp1[12] = 32'h6543_FF21;
    n_checks++; if (obs_lat !== 4) begin n_fail++; $display("FAIL t4_bstore_lat: got %0d required 4", obs_lat); end
    n_checks++; if (obs_we_cnt !== 1) begin n_fail++; $display("FAIL t4_bstore_we: got %0d required 1", obs_we_cnt); end
    n_checks++; if (obs_we_lat !== 3) begin n_fail++; $display("FAIL t4_bstore_we_cycle: got %0d required 3", obs_we_lat); end
    n_checks++; if (mem1[12] !== 32'h6543_FF21) begin n_fail++; $display("FAIL t4_ram_word: got %h required 6543ff21", mem1[12]); end
    xact(1'b0, 1'b0, 1'b1, 8'h33, 32'h0);
    n_checks++; if (obs_rdata !== 32'h0000_0065) begin n_fail++; $display("FAIL t4_bload_33: got %h required 00000065", obs_rdata); end
    n_checks++; if (obs_lat !== 3) begin n_fail++; $display("FAIL t4_bload_lat: got %0d required 3", obs_lat); end
    xact(1'b0, 1'b0, 1'b1, 8'h31, 32'h0);
    n_checks++; if (obs_rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL t4_bload_31: got %h required 000000ff", obs_rdata); end
  endtask
`else
  task automatic test_byte_ignored();
    xact(1'b0, 1'b1, 1'b1, 8'h31, 32'h5A5A_0001);
    exp1[12] = 32'h5A5A_0001;
    n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL t4_word_store_lat: got %0d required 2", obs_lat); end
    n_checks++; if (mem1[12] !== 32'h5A5A_0001) begin n_fail++; $display("FAIL t4_ram_word: got %h required 5a5a0001", mem1[12]); end
    xact(1'b0, 1'b0, 1'b1, 8'h33, 32'h0);
    n_checks++; if (obs_rdata !== 32'h5A5A_0001) begin n_fail++; $display("FAIL t4_word_load: got %h required 5a5a0001", obs_rdata); end
  endtask
`endif

  task automatic test_reset_mid_op();
    int r0;
    use2 = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_byte = 1'b0; req_addr = 8'h10; req_v = 1'b1;
    n_checks++; if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL t5_ready_idle: got %b required 1", req_ready1); end
    @(posedge clk);
    #1 req_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready1, resp_valid1, resp_rdata1, ram_we1, ram_addr1, ram_din1} !== 72'h0)
      begin n_fail++; $display("FAIL t5_outputs_in_reset: got %h required 0", {req_ready1, resp_valid1, resp_rdata1, ram_we1, ram_addr1, ram_din1}); end
    r0 = mon_resp;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready1 !== 1'b0) begin n_fail++; $display("FAIL t5_ready_at_release: got %b required 0", req_ready1); end
    @(negedge clk);
    n_checks++; if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL t5_ready_after: got %b required 1", req_ready1); end
    repeat (3) @(negedge clk);
    n_checks++; if (mon_resp !== r0) begin n_fail++; $display("FAIL t5_no_resp: got %0d required %0d", mon_resp, r0); end
    req_write = 1'b1; req_addr = 8'h08; req_wdata = 32'h5555_AAAA; req_v = 1'b1;
    @(posedge clk);
    #1 req_v = 1'b0;
    n_checks++; if (ram_we1 !== 1'b1) begin n_fail++; $display("FAIL t5_we_issue: got %b required 1", ram_we1); end
    rst = 1'b1;
    #1;
    n_checks++; if (ram_we1 !== 1'b0) begin n_fail++; $display("FAIL t5_we_drop: got %b required 0", ram_we1); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem1[2] !== exp1[2]) begin n_fail++; $display("FAIL t5_no_write: got %h required %h", mem1[2], exp1[2]); end
  endtask

  task automatic test_top_word_lat2();
    xact(1'b1, 1'b1, 1'b0, 8'hFC, 32'hD0D0_D0D0);
    n_checks++; if (obs_addr1 !== 6'd63) begin n_fail++; $display("FAIL t6_ram_addr: got %0d required 63", obs_addr1); end
    n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL t6_store_lat: got %0d required 2", obs_lat); end
    n_checks++; if (mem2[63] !== 32'hD0D0_D0D0) begin n_fail++; $display("FAIL t6_ram_word: got %h required d0d0d0d0", mem2[63]); end
    xact(1'b1, 1'b0, 1'b0, 8'hFC, 32'h0);
    n_checks++; if (obs_lat !== 4) begin n_fail++; $display("FAIL t6_load_lat: got %0d required 4", obs_lat); end
    n_checks++; if (obs_rdata !== 32'hD0D0_D0D0) begin n_fail++; $display("FAIL t6_load_data: got %h required d0d0d0d0", obs_rdata); end
    n_checks++; if (obs_pulse2 !== 1'b0) begin n_fail++; $display("FAIL t6_pulse_len: got %b required 0", obs_pulse2); end
    use2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_unaligned_word();
`ifdef DMP_BYTE_ACCESS_EN
    test_byte_access();
`else
    test_byte_ignored();
`endif
    test_reset_mid_op();
    test_top_word_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
